instr_prefetch_buffer: RTL
==========================

Name: instr_prefetch_buffer

Overview:
- Sits directly upstream of the fetch stage, between the instruction memory bus (req/gnt/rvalid/rdata) and fetch.
- Autonomously issues sequential word fetches and keeps up to DEPTH requests outstanding.
- Buffers returned instructions with their PCs in a small FIFO and presents them to fetch through a valid/ready handshake.
- On a branch redirect it flushes buffered entries and discards in-flight responses.

Parameters:
- DEPTH, 2: FIFO entries; also the maximum outstanding requests (outstanding + occupancy <= DEPTH). Must be a power of two, >= 2.
- BOOT_ADDR, 32'h0000_0000: first fetch address after reset. Must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- redirect_in  in  1  pulse: flush and restart fetching at redirect_addr_in.
- redirect_addr_in  in  32  new PC; bits [1:0] are ignored (forced to 0).
- instr_req_out  out  1  memory request.
- instr_addr_out  out  32  request address, word-aligned.
- instr_gnt_in  in  1  request accepted this cycle.
- instr_rvalid_in  in  1  response valid; responses return in order.
- instr_rdata_in  in  32  response data.
- fetch_valid_out  out  1  head entry is available.
- fetch_ready_in  in  1  fetch consumes the head entry this cycle.
- fetch_instr_out  out  32  head instruction.
- fetch_pc_out  out  32  head PC.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - req_pc = BOOT_ADDR; FIFO empty; outstanding = 0; discard = 0.
  - instr_req_out = 0, fetch_valid_out = 0; fetch_instr_out and fetch_pc_out = 0.
  - Reset mid-transaction abandons all state. Responses to pre-reset requests are not tracked; the bus is required to be quiet during reset.
- Request issue:
  - instr_req_out = !rst && (outstanding + occupancy + discard < DEPTH), or a request is already pending.
  - Once asserted, instr_req_out and instr_addr_out are held stable until instr_gnt_in=1. No retraction, including across a redirect.
  - On grant: outstanding += 1 and req_pc += 4. Wraps from 32'hFFFF_FFFC to 0.
- Response:
  - On instr_rvalid_in: outstanding -= 1.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise: push {resp_pc, instr_rdata_in}, where resp_pc is a separate counter advancing by 4 per accepted response.
  - rvalid with outstanding = 0 is a protocol error (assertion); state is unchanged.
- Fetch side:
  - fetch_valid_out = !empty; outputs show the head entry (registered FIFO storage).
  - Pop when fetch_valid_out && fetch_ready_in.
  - Push and pop in the same cycle when full is legal and occupancy is unchanged.
- Redirect, effective on the edge where redirect_in=1:
  - FIFO cleared; discard = outstanding. A grant and an rvalid in the same cycle are also accounted, so discard = outstanding + gnt − rvalid.
  - req_pc = resp_pc = {redirect_addr_in[31:2], 2'b00}.
  - A pending ungranted request keeps its old address until granted; that grant then increments discard, and req_pc is not advanced.
  - fetch_valid_out = 0 in the following cycle.
  - A pop in the redirect cycle is permitted; the consumer must ignore it.
- Latency: first response to fetch_valid_out is 1 cycle (registered).
- Counter widths: outstanding and discard use $clog2(DEPTH)+1 bits; they never exceed DEPTH.

Optional Feature:
- Macro: INSTR_PREFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, discard = 0, instr_rvalid_in=1 and no redirect, the response is presented combinationally the same cycle: fetch_valid_out=1, with rdata and resp_pc on the outputs.
  - If fetch_ready_in=1 it is consumed without a push; otherwise it is pushed.
  - Latency is 0 cycles.
- Undefined: latency is 1 cycle and the outputs come purely from FIFO registers.

Decomposition:
- Shared package instr_pkg:
  - typedef fetch_entry_t (packed struct: pc[31:0], instr[31:0]).
  - Localparams INSTR_BYTES = 4 and BOOT_ADDR_DEFAULT.
  - Opcode constants OPC_BRANCH = 7'b1100011 and OPC_JAL = 7'b1101111, shared with fetch/decode.
- Sub-module instr_fifo:
  - Synchronous FIFO of fetch_entry_t with DEPTH and a flush input.
  - Outputs: full, empty, count.

Test Plan:
- Reset, gnt always 1, rvalid 1 cycle after grant, ready=1 → addresses 0x0, 0x4, 0x8…; fetch gets pc 0x0/instr D0, then 0x4/D1, in order.
- ready=0 with DEPTH=2 → after 2 responses FIFO full; instr_req_out=0; no further grants until one pop.
- Grant at cycle N, redirect_in=1 with addr 0x100 at N+1, rvalid for old address at N+2 → that response dropped; next request addr 0x100; first fetch_pc_out = 0x100.
- req pending with gnt=0 for 3 cycles, redirect at 0x200 → addr held at old value until gnt; that response discarded; then 0x200 requested.
- redirect_addr_in = 0x103 → requests 0x100; req_pc at 0xFFFF_FFFC then grant → next addr 0x0.
- With INSTR_PREFETCH_BYPASS_EN, FIFO empty, rvalid=1, ready=1 → fetch_valid_out=1 same cycle, FIFO stays empty; without the macro valid rises the next cycle.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch path.
//
// Contents:
//   fetch_entry_t      buffered fetch entry {pc, instr}
//   INSTR_BYTES        bytes per instruction word
//   BOOT_ADDR_DEFAULT  default first fetch address after reset
//   OPC_BRANCH/OPC_JAL major opcodes shared with fetch/decode
//   word_align()       clears the byte-offset bits of an address
package instr_pkg;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries with a flush input.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         empties the FIFO (wins over a push in the same cycle)
//   push, push_entry  write an entry; accepted when not full or when popping
//   pop           remove the head entry; ignored when empty
//   head_entry    registered head entry
//   full, empty, count  occupancy status
module instr_fifo
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output fetch_entry_t               head_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic do_push;
    logic do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer between the instruction memory bus and fetch.
// Issues sequential word fetches, keeps up to DEPTH requests in flight, buffers
// responses with their PCs and hands them to fetch over valid/ready. A redirect
// flushes the buffer and discards responses that are still in flight.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   redirect_in, redirect_addr_in     flush and restart at the given PC
//   instr_req_out, instr_addr_out     memory request (held until granted)
//   instr_gnt_in                      request accepted
//   instr_rvalid_in, instr_rdata_in   in-order response
//   fetch_valid_out, fetch_ready_in   fetch handshake
//   fetch_instr_out, fetch_pc_out     head instruction and its PC
//
// Build option: define INSTR_PREFETCH_BYPASS_EN to present a response to fetch
// in the same cycle it arrives when nothing is buffered ahead of it.
module instr_prefetch_buffer
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_in,
    input  logic [31:0] redirect_addr_in,
    output logic        instr_req_out,
    output logic [31:0] instr_addr_out,
    input  logic        instr_gnt_in,
    input  logic        instr_rvalid_in,
    input  logic [31:0] instr_rdata_in,
    output logic        fetch_valid_out,
    input  logic        fetch_ready_in,
    output logic [31:0] fetch_instr_out,
    output logic [31:0] fetch_pc_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic          pend_stale_q, pend_stale_d;

    logic          rv_ok;
    logic          accept;
    logic          gnt;
    logic          stale_gnt;
    logic [CW+1:0] budget;

    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    always_comb begin
        // Responses with nothing outstanding are ignored.
        rv_ok  = instr_rvalid_in && (out_q != '0);
        accept = rv_ok && (disc_q == '0);

        budget = {2'b00, out_q} + {2'b00, fifo_count} + {2'b00, disc_q};

        instr_req_out  = !rst && (pend_q || (budget < (CW + 2)'(DEPTH)));
        instr_addr_out = pend_q ? pend_addr_q : req_pc_q;

        gnt       = instr_req_out && instr_gnt_in;
        // A request raised before a redirect returns data for the old stream.
        stale_gnt = gnt && pend_q && pend_stale_q;

        out_d = out_q + CW'(gnt) - CW'(rv_ok);

        if (redirect_in) begin
            disc_d    = out_d;
            req_pc_d  = word_align(redirect_addr_in);
            resp_pc_d = word_align(redirect_addr_in);
        end else begin
            disc_d    = disc_q + CW'(stale_gnt) - CW'(rv_ok && (disc_q != '0));
            req_pc_d  = (gnt && !stale_gnt) ? req_pc_q + 32'(INSTR_BYTES) : req_pc_q;
            resp_pc_d = accept ? resp_pc_q + 32'(INSTR_BYTES) : resp_pc_q;
        end

        pend_d       = instr_req_out && !instr_gnt_in;
        pend_addr_d  = instr_addr_out;
        pend_stale_d = pend_d && (redirect_in || pend_stale_q);

        fifo_entry = '{pc: resp_pc_q, instr: instr_rdata_in};
        fifo_pop   = fetch_ready_in && !fifo_empty;
    end

`ifdef INSTR_PREFETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass          = fifo_empty && accept && !redirect_in;
        fifo_push       = accept && !redirect_in && !(bypass && fetch_ready_in);
        fetch_valid_out = !fifo_empty || bypass;
        fetch_instr_out = bypass ? instr_rdata_in : fifo_head.instr;
        fetch_pc_out    = bypass ? resp_pc_q : fifo_head.pc;
    end
`else
    always_comb begin
        fifo_push       = accept && !redirect_in;
        fetch_valid_out = !fifo_empty;
        fetch_instr_out = fifo_head.instr;
        fetch_pc_out    = fifo_head.pc;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q     <= BOOT_ADDR;
            resp_pc_q    <= BOOT_ADDR;
            out_q        <= '0;
            disc_q       <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_stale_q <= 1'b0;
        end else begin
            req_pc_q     <= req_pc_d;
            resp_pc_q    <= resp_pc_d;
            out_q        <= out_d;
            disc_q       <= disc_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_stale_q <= pend_stale_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_without_request: assert (!(instr_rvalid_in && (out_q == '0)));
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_in),
        .push       (fifo_push),
        .push_entry (fifo_entry),
        .pop        (fifo_pop),
        .head_entry (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Fullness is implied by the request budget; kept for observability.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
